// File: rtl/multiply32x16_unsigned_shift_add_accumulate_if.sv
// Handshake and operand bundle for the 32x16 shift-add multiply-accumulate.
// The master drives start and operands; the slave returns the product and status.
interface multiply32x16_unsigned_shift_add_accumulate_if #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_B = 16,
  parameter int COUNT_W = 4
);
  logic                       start;
  logic [WIDTH_A-1:0]         multiplicand;
  logic [WIDTH_B-1:0]         multiplier;
  logic [WIDTH_B-1:0]         addend;
  logic [WIDTH_A+WIDTH_B-1:0] product;
  logic                       ready;
  logic                       busy;
  logic [COUNT_W-1:0]         count;

  modport master (
    output start, multiplicand, multiplier, addend,
    input  product, ready, busy, count
  );

  modport slave (
    input  start, multiplicand, multiplier, addend,
    output product, ready, busy, count
  );
endinterface

// File: rtl/multiply32x16_unsigned_shift_add_accumulate.sv
// Sequential unsigned multiply-accumulate: product = multiplicand * multiplier + addend,
// one multiplier bit per clock, fixed 16-iteration latency.
module multiply32x16_unsigned_shift_add_accumulate #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_B = 16,
  parameter int COUNT_W = 4
) (
  input  logic clock,
  input  logic reset,
  multiply32x16_unsigned_shift_add_accumulate_if.slave bus
);
  localparam int PW = WIDTH_A + WIDTH_B;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nx;
  logic [PW-1:0]      acc, acc_nx;
  logic [PW-1:0]      a_q, a_nx;
  logic [WIDTH_B-1:0] b_q, b_nx;
  logic [COUNT_W-1:0] cnt, cnt_nx;
  logic               rdy, rdy_nx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      rdy   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      cnt   <= cnt_nx;
      rdy   <= rdy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    a_nx     = a_q;
    b_nx     = b_q;
    cnt_nx   = cnt;
    rdy_nx   = rdy;
    case (state)
      IDLE: begin
        // ready does not block acceptance; a new start simply clears it
        if (bus.start) begin
          acc_nx   = {{WIDTH_A{1'b0}}, bus.addend};
          a_nx     = {{WIDTH_B{1'b0}}, bus.multiplicand};
          b_nx     = bus.multiplier;
          cnt_nx   = '0;
          rdy_nx   = 1'b0;
          state_nx = RUN;
        end
      end
      RUN: begin
        // sum cannot exceed 2^48-2^32, so the 48-bit add never wraps
        if (b_q[cnt]) acc_nx = acc + (a_q << cnt);
        if (cnt == COUNT_W'(WIDTH_B - 1)) begin
          rdy_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.product = acc;
  assign bus.ready   = rdy;
  assign bus.busy    = (state == RUN);
  assign bus.count   = cnt;
endmodule

// File: tb/tb_multiply32x16_unsigned_shift_add_accumulate.sv
// Scoreboard bench for the shift-add multiply-accumulate: expected products are
// queued at start and popped when ready rises.
module tb_multiply32x16_unsigned_shift_add_accumulate;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [47:0] sb[$];
  logic rdy_q = 1'b0;

  multiply32x16_unsigned_shift_add_accumulate_if #(.WIDTH_A(32), .WIDTH_B(16), .COUNT_W(4)) bus ();

  multiply32x16_unsigned_shift_add_accumulate #(.WIDTH_A(32), .WIDTH_B(16), .COUNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // result monitor: pop on each rising ready
  always @(negedge clock) begin
    if (!reset) begin
      rdy_q = 1'b0;
    end else begin
      if (bus.ready && !rdy_q) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) chk("product", 64'(bus.product), 64'(sb.pop_front()));
      end
      rdy_q = bus.ready;
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [15:0] b, input logic [15:0] c);
    @(negedge clock);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.addend       = c;
    sb.push_back(48'(a) * 48'(b) + 48'(c));
    @(posedge clock);
    #1;
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = 16'($urandom);
    bus.addend       = 16'($urandom);
    chk("acc_busy", 64'(bus.busy), 64'd1);
    chk("acc_ready", 64'(bus.ready), 64'd0);
    chk("acc_count", 64'(bus.count), 64'd0);
  endtask

  // steps E1..E16; inj>0 re-asserts start with junk operands before edge inj
  task automatic wait_done(input int inj);
    for (int k = 1; k <= 16; k++) begin
      if (k == inj) begin
        bus.start        = 1'b1;
        bus.multiplicand = 32'hDEAD_BEEF;
        bus.multiplier   = 16'hFFFF;
        bus.addend       = 16'h1234;
      end
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      if (k < 16) begin
        chk("run_busy", 64'(bus.busy), 64'd1);
        chk("run_count", 64'(bus.count), 64'(k));
      end else begin
        chk("done_busy", 64'(bus.busy), 64'd0);
        chk("done_ready", 64'(bus.ready), 64'd1);
        chk("done_count", 64'(bus.count), 64'd15);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0; bus.addend = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_product", 64'(bus.product), 64'd0);
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    @(negedge clock) reset = 1'b1;

    // round trip
    start_op(32'h7FFF_FFFF, 16'h0002, 16'h0001);
    wait_done(0);
    chk("rt_const", 64'(bus.product), 64'h0000_FFFF_FFFF);

    // maximum operands, then hold in idle
    start_op(32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF);
    wait_done(0);
    repeat (5) @(posedge clock);
    #1;
    chk("max_hold", 64'(bus.product), 64'hFFFF_0000_0000);
    chk("hold_ready", 64'(bus.ready), 64'd1);
    chk("hold_count", 64'(bus.count), 64'd15);

    // zero multiplier / zero multiplicand
    start_op(32'h1234_5678, 16'h0000, 16'hABCD);
    wait_done(0);
    start_op(32'h0000_0000, 16'h1234, 16'h0000);
    wait_done(0);

    // ignored start mid-run
    start_op(32'h0000_0003, 16'h0005, 16'h0000);
    wait_done(5);
    chk("ign_const", 64'(bus.product), 64'h0000_0000_000F);
    repeat (3) @(posedge clock);
    #1;
    chk("ign_idle", 64'(bus.busy), 64'd0);

    // asynchronous reset between E7 and E8
    start_op(32'h0ABC_DEF0, 16'h7777, 16'h1111);
    repeat (7) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mrst_product", 64'(bus.product), 64'd0);
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_ready", 64'(bus.ready), 64'd0);
    chk("mrst_count", 64'(bus.count), 64'd0);
    sb.delete();
    @(negedge clock) reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("post_rst_busy", 64'(bus.busy), 64'd0);
    start_op(32'h0001_0000, 16'h0010, 16'h0002);
    wait_done(0);

    // back-to-back: start on the edge where ready is high
    start_op(32'h0000_00FF, 16'h00FF, 16'h0001);
    wait_done(0);
    chk("b2b_const", 64'(bus.product), 64'h0000_0000_FE02);

    // a few random operands
    for (int i = 0; i < 4; i++) begin
      start_op($urandom, 16'($urandom), 16'($urandom));
      wait_done(0);
    end

    repeat (3) @(posedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
